conv_window_index_gen: RTL

Upstream stage of the index-to-memory-address converter. Raster-scans every output pixel of a 640x480 or 1024x768 frame and, per pixel, emits the KSIZE x KSIZE convolution-window neighbour coordinates as packed {row, col} indices, clamped at the frame borders. Output is a valid/ready stream; its INDEX_ADDRESS format is the converter's input format: row in [31:16], col in [15:0]. A START/DONE pair lets the pipelined CPU's convolution control launch one frame pass.

---
 rtl/conv_window_index_gen_if.sv | 24 ++
 rtl/conv_window_index_gen.sv | 115 +++++++++++
 2 files changed

// File: rtl/conv_window_index_gen_if.sv
// Stream/control bundle between the convolution controller and the window index generator.
// The master side launches a frame and consumes indices; the slave side is the generator.
interface conv_window_index_gen_if;
  logic        START;
  logic        SIZE_IMAGE;
  logic        READY_IN;
  logic        VALID_OUT;
  logic [31:0] INDEX_ADDRESS;
  logic [5:0]  TAP;
  logic        TAP_LAST;
  logic        FRAME_LAST;
  logic        BUSY;
  logic        DONE;

  modport master (
    output START, SIZE_IMAGE, READY_IN,
    input  VALID_OUT, INDEX_ADDRESS, TAP, TAP_LAST, FRAME_LAST, BUSY, DONE
  );

  modport slave (
    input  START, SIZE_IMAGE, READY_IN,
    output VALID_OUT, INDEX_ADDRESS, TAP, TAP_LAST, FRAME_LAST, BUSY, DONE
  );
endinterface

// File: rtl/conv_window_index_gen.sv
// Raster-scans a frame and streams the clamped KSIZE x KSIZE neighbour coordinates
// of every output pixel as {row, col}, one index per accepted transfer.
module conv_window_index_gen #(
  parameter int KSIZE   = 3,
  parameter int W_SMALL = 640,
  parameter int H_SMALL = 480,
  parameter int W_LARGE = 1024,
  parameter int H_LARGE = 768
) (
  input logic                     CLK,
  input logic                     RESET,
  conv_window_index_gen_if.slave  bus
);

  localparam int R = (KSIZE - 1) / 2;
  localparam logic signed [16:0] RS = 17'(R);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q, state_d;
  logic        size_q;
  logic [2:0]  kx_q, ky_q;
  logic [15:0] px_q, py_q;

  logic [15:0] w_m1, h_m1;
  logic        kx_end, ky_end, px_end, py_end;
  logic        tap_last, frame_last, xfer;

  assign w_m1 = size_q ? 16'(W_LARGE - 1) : 16'(W_SMALL - 1);
  assign h_m1 = size_q ? 16'(H_LARGE - 1) : 16'(H_SMALL - 1);

  assign kx_end     = (kx_q == 3'(KSIZE - 1));
  assign ky_end     = (ky_q == 3'(KSIZE - 1));
  assign px_end     = (px_q == w_m1);
  assign py_end     = (py_q == h_m1);
  assign tap_last   = kx_end & ky_end;
  assign frame_last = tap_last & px_end & py_end;
  assign xfer       = (state_q == RUN) & bus.READY_IN;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = RUN;
      RUN:     if (xfer && frame_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan counters move only on an accepted transfer, so outputs hold under backpressure.
  // The final transfer wraps every counter back to zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      size_q <= 1'b0;
      kx_q   <= '0;
      ky_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else if (state_q == IDLE && bus.START) begin
      size_q <= bus.SIZE_IMAGE;
      kx_q   <= '0;
      ky_q   <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else if (xfer) begin
      if (kx_end) begin
        kx_q <= '0;
        if (ky_end) begin
          ky_q <= '0;
          if (px_end) begin
            px_q <= '0;
            py_q <= py_end ? 16'd0 : py_q + 16'd1;
          end else begin
            px_q <= px_q + 16'd1;
          end
        end else begin
          ky_q <= ky_q + 3'd1;
        end
      end else begin
        kx_q <= kx_q + 3'd1;
      end
    end
  end

  // Border clamp on a 17-bit signed sum so px+kx-R never wraps.
  logic signed [16:0] col_s, row_s;
  logic [15:0]        col, row;

  assign col_s = signed'({1'b0, px_q}) + signed'({14'b0, kx_q}) - RS;
  assign row_s = signed'({1'b0, py_q}) + signed'({14'b0, ky_q}) - RS;

  always_comb begin
    col = col_s[15:0];
    row = row_s[15:0];
    if (col_s[16])                            col = '0;
    else if (col_s > signed'({1'b0, w_m1}))   col = w_m1;
    if (row_s[16])                            row = '0;
    else if (row_s > signed'({1'b0, h_m1}))   row = h_m1;
  end

  assign bus.VALID_OUT     = (state_q == RUN);
  assign bus.BUSY          = (state_q == RUN);
  assign bus.DONE          = (state_q == FIN);
  assign bus.INDEX_ADDRESS = {row, col};
  assign bus.TAP           = 6'(ky_q) * 6'(KSIZE) + 6'(kx_q);
  assign bus.TAP_LAST      = (state_q == RUN) & tap_last;
  assign bus.FRAME_LAST    = (state_q == RUN) & frame_last;

endmodule
